imem_loader: RTL and testbench

- Writer side of the instruction memory: takes a byte stream from a host link, assembles 18-bit instruction words and writes them to consecutive instruction memory addresses.
- Holds the CPU (drives its clear) while a load is in progress.
- Sits beside the CPU top. Its write port feeds the instruction memory write side; the core keeps the read side.

---
 rtl/imem_loader_if.sv | 22 ++
 rtl/imem_loader.sv | 166 ++++++++++++++++
 tb/tb_imem_loader.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Host byte stream and instruction memory write port of the loader.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 18
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: host bytes -> 18-bit words -> imem writes.
// Optional trailing XOR checksum byte: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 18,
    parameter int BASE_ADDR  = 0
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                start,
    imem_loader_if.slave        bus,
    output logic                cpu_hold,
    output logic                done,
    output logic                error,
    output logic [ADDR_WIDTH:0] words_loaded
);
    localparam int unsigned MAX_WORDS = (1 << ADDR_WIDTH) - BASE_ADDR;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_B0,
        S_B1,
        S_B2,
        S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERROR
    } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_FIN = S_CHK;
`else
    localparam state_t S_FIN = S_DONE;
`endif

    state_t                state;
    state_t                next;
    logic [7:0]            len_lo;
    logic [7:0]            b0;
    logic [7:0]            b1;
    logic [15:0]           len;
    logic [15:0]           n_in;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  accept;
    logic                  launch;
    logic                  over;
    logic                  last_word;
    logic                  b2_bad;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            csum;
`endif

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign bus.in_ready = state inside
        {S_LEN_LO, S_LEN_HI, S_B0, S_B1, S_B2, S_CHK};
`else
    assign bus.in_ready = state inside
        {S_LEN_LO, S_LEN_HI, S_B0, S_B1, S_B2};
`endif

    assign accept    = bus.in_valid && bus.in_ready;
    assign launch    = start && (state inside {S_IDLE, S_DONE, S_ERROR});
    assign n_in      = {bus.in_data, len_lo};
    assign over      = 32'(n_in) > MAX_WORDS;
    assign last_word = (32'(count) + 32'd1) == 32'(len);
    assign b2_bad    = bus.in_data[7:2] != 6'd0;

    assign bus.mem_we    = state == S_WRITE;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign cpu_hold      = !(state inside {S_IDLE, S_DONE});
    assign done          = state == S_DONE;
    assign error         = state == S_ERROR;
    assign words_loaded  = count;

    always_comb begin
        next = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERROR:
                if (start) next = S_LEN_LO;
            S_LEN_LO:
                if (accept) next = S_LEN_HI;
            S_LEN_HI:
                if (accept) begin
                    if (over)            next = S_ERROR;
                    else if (n_in == '0) next = S_FIN;
                    else                 next = S_B0;
                end
            S_B0:
                if (accept) next = S_B1;
            S_B1:
                if (accept) next = S_B2;
            S_B2:
                if (accept) next = b2_bad ? S_ERROR : S_WRITE;
            S_WRITE:
                next = last_word ? S_FIN : S_B0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK:
                if (accept) begin
                    next = (bus.in_data == csum) ? S_DONE : S_ERROR;
                end
`endif
            default:
                next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state   <= S_IDLE;
            len_lo  <= '0;
            len     <= '0;
            b0      <= '0;
            b1      <= '0;
            addr    <= '0;
            count   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum    <= '0;
`endif
        end else begin
            state <= next;
            if (launch) begin
                addr  <= ADDR_WIDTH'(BASE_ADDR);
                count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum  <= '0;
`endif
            end
            if (accept) begin
                case (state)
                    S_LEN_LO: len_lo <= bus.in_data;
                    S_LEN_HI: len    <= n_in;
                    S_B0:     b0     <= bus.in_data;
                    S_B1:     b1     <= bus.in_data;
                    S_B2:
                        // Output regs only move on a good word, so they
                        // keep showing the last real write otherwise.
                        if (!b2_bad) begin
                            addr_q  <= addr;
                            wdata_q <= DATA_WIDTH'(
                                {bus.in_data[1:0], b1, b0});
                        end
                    default: ;
                endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (state inside {S_B0, S_B1, S_B2}) begin
                    csum <= csum ^ bus.in_data;
                end
`endif
            end
            if (state == S_WRITE) begin
                addr  <= addr + 1'b1;
                count <= count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a stream model.
module tb_imem_loader;
    localparam int AW   = 11;
    localparam int MAXW = 2 ** AW;

    logic          clock = 1'b0;
    logic          clear;
    logic          start;
    logic          cpu_hold;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    imem_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(18)) bus ();

    imem_loader #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(18),
        .BASE_ADDR (0)
    ) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .bus         (bus),
        .cpu_hold    (cpu_hold),
        .done        (done),
        .error       (error),
        .words_loaded(words_loaded)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          addr;
        logic [17:0] data;
        int          cyc;
    } wr_t;
    typedef logic [7:0] bq_t[$];

    wr_t got_w[$];
    wr_t exp_w[$];
    int  cycle = 0;
    int  n_cmp = 0;
    int  n_err = 0;
    int  exp_used;
    int  exp_words;
    bit  exp_ok;

    always @(posedge clock) cycle <= cycle + 1;

    always @(negedge clock) begin
        if (bus.mem_we === 1'b1) begin
            got_w.push_back('{int'(bus.mem_addr), bus.mem_wdata, cycle});
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: parse the stream by its format rules.
    task automatic run_model(input bq_t s);
        int          n;
        logic [7:0]  x;
        logic [7:0]  c0, c1, c2;
        exp_w.delete();
        exp_used  = 2;
        exp_words = 0;
        x = 8'h00;
        n = int'({s[1], s[0]});
        if (n > MAXW) begin
            exp_ok = 1'b0;
            return;
        end
        for (int w = 0; w < n; w++) begin
            c0 = s[2 + 3 * w];
            c1 = s[3 + 3 * w];
            c2 = s[4 + 3 * w];
            exp_used += 3;
            if (c2 >= 8'd4) begin
                exp_ok = 1'b0;
                exp_words = w;
                return;
            end
            exp_w.push_back('{w, {c2[1:0], c1, c0}, 0});
            x = x ^ c0 ^ c1 ^ c2;
        end
        exp_words = n;
`ifdef IMEM_LOADER_CHECKSUM_EN
        exp_used += 1;
        exp_ok = s[exp_used - 1] == x;
`else
        exp_ok = 1'b1;
`endif
    endtask

    // mode 0: valid held, 1: toggling, 2: random
    task automatic send(input bq_t s, input int nbytes, input int mode);
        int i = 0;
        int c = 0;
        bit v;
        bit took;
        while (i < nbytes && c < 2000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (c % 2) == 0;
                default: v = $urandom_range(0, 1) == 1;
            endcase
            c++;
            bus.in_valid = v;
            bus.in_data  = v ? s[i] : 8'($urandom);
            took = v && bus.in_ready;
            @(negedge clock);
            if (took) i++;
        end
        bus.in_valid = 1'b0;
        if (c >= 2000) chk("send_timeout", 32'(i), 32'(nbytes));
    endtask

    task automatic run_load(input bq_t s, input int mode);
        int k = 0;
        got_w.delete();
        run_model(s);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("hold_rise", 32'(cpu_hold), 32'd1);
        send(s, exp_used, mode);
        while (!(done || error) && k < 60) begin
            @(negedge clock);
            k++;
        end
        chk("status", 32'({done, error}), exp_ok ? 32'd2 : 32'd1);
        chk("words", 32'(words_loaded), 32'(exp_words));
        chk("hold_end", 32'(cpu_hold), exp_ok ? 32'd0 : 32'd1);
        chk("nwrites", 32'(got_w.size()), 32'(exp_w.size()));
        foreach (exp_w[i]) begin
            if (i < got_w.size()) begin
                chk("waddr", 32'(got_w[i].addr), 32'(exp_w[i].addr));
                chk("wdata", 32'(got_w[i].data), 32'(exp_w[i].data));
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rdy"}, 32'(bus.in_ready), 0);
        chk({tag, "_we"}, 32'(bus.mem_we), 0);
        chk({tag, "_addr"}, 32'(bus.mem_addr), 0);
        chk({tag, "_wdata"}, 32'(bus.mem_wdata), 0);
        chk({tag, "_hold"}, 32'(cpu_hold), 0);
        chk({tag, "_flags"}, 32'({done, error}), 0);
        chk({tag, "_words"}, 32'(words_loaded), 0);
    endtask

    initial begin
        bq_t         s;
        int          n;
        logic [17:0] d;
        logic [7:0]  x;

        clear = 1'b1;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clock);
        chk_zero("reset");
        clear = 1'b0;
        @(negedge clock);

        s = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h03, 8'hFF, 8'hFF, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
        s.push_back(8'h25);
`endif
        run_load(s, 0);
        chk("w0_data", 32'(got_w.size() > 0 ? got_w[0].data : 0),
            32'h31234);
        if (got_w.size() >= 2) begin
            chk("gap", 32'(got_w[1].cyc - got_w[0].cyc), 32'd4);
        end
        chk("addr_hold", 32'(bus.mem_addr), 32'd1);
        chk("wdata_hold", 32'(bus.mem_wdata), 32'h0FFFF);

        run_load(s, 1);

        s = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
        s.push_back(8'h00);
`endif
        run_load(s, 0);

        s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h04};
        run_load(s, 0);
        s = '{8'h01, 8'h00, 8'h55, 8'hAA, 8'h02};
`ifdef IMEM_LOADER_CHECKSUM_EN
        s.push_back(8'h55 ^ 8'hAA ^ 8'h02);
`endif
        run_load(s, 2);

        s = '{8'h01, 8'h08};
        run_load(s, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        s = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h01, 8'h32};
        run_load(s, 0);
        s = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h01, 8'h33};
        run_load(s, 0);
`endif

        // Abort with clear while the third word is half received.
        got_w.delete();
        s = '{8'h05, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h02,
              8'h06};
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        send(s, 9, 0);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        chk_zero("clr");
        chk("clr_nw", 32'(got_w.size()), 32'd2);
        if (got_w.size() >= 2) begin
            chk("clr_w1", 32'({got_w[1].addr[3:0], got_w[1].data}),
                32'({4'd1, 18'h20504}));
        end

        for (int it = 0; it < 25; it++) begin
            s.delete();
            n = $urandom_range(0, 5);
            if ($urandom_range(0, 7) == 0) n = MAXW + $urandom_range(1, 300);
            s.push_back(8'(n));
            s.push_back(8'(n >> 8));
            x = 8'h00;
            if (n <= MAXW) begin
                for (int w = 0; w < n; w++) begin
                    d = 18'($urandom);
                    s.push_back(d[7:0]);
                    s.push_back(d[15:8]);
                    if ($urandom_range(0, 15) == 0) begin
                        s.push_back({6'($urandom_range(1, 63)), d[17:16]});
                    end else begin
                        s.push_back({6'd0, d[17:16]});
                    end
                    x = x ^ s[s.size() - 1] ^ s[s.size() - 2]
                          ^ s[s.size() - 3];
                end
                if ($urandom_range(0, 5) == 0) x = x ^ 8'($urandom_range(1, 255));
                s.push_back(x);
            end
            run_load(s, 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
